tcm_dport_adapter: RTL and testbench

// - Upstream of the 64-bit dual-port TCM RAM: adapts the CPU's 32-bit byte-addressed data port to one RAM port.
// - Steers write lanes, selects the 32-bit read half, and tracks the RAM's fixed 1-cycle read latency.
// - Buffers responses in a small FIFO so the requester may back-pressure them.

---
 rtl/tcm_dport_adapter_if.sv | 44 ++++
 rtl/tcm_dport_adapter.sv | 179 +++++++++++++++++
 tb/tb_tcm_dport_adapter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_dport_adapter_if.sv
// ----------------------------------------------------------------------------
// tcm_dport_adapter_if
// CPU data-port bundle between a 32-bit requester and tcm_dport_adapter.
//
// Request (requester -> adapter):
//   mem_addr_i[31:0], mem_data_wr_i[31:0], mem_rd_i, mem_wr_i[3:0],
//   mem_req_tag_i[TAG_W-1:0]
//   mem_accept_o: the request is taken in every cycle where it is asserted
//   together with mem_accept_o.
// Response (adapter -> requester):
//   mem_ack_o, mem_data_rd_o[31:0], mem_resp_tag_o[TAG_W-1:0], mem_error_o
//   mem_resp_ready_i: the response is consumed in every cycle where
//   mem_ack_o & mem_resp_ready_i; while mem_ack_o & !mem_resp_ready_i the
//   response fields hold stable.
//
// Modports: slave = adapter side, master = requester side.
// ----------------------------------------------------------------------------
interface tcm_dport_adapter_if #(
    parameter int TAG_W = 8
);
    logic [31:0]      mem_addr_i;
    logic [31:0]      mem_data_wr_i;
    logic             mem_rd_i;
    logic [3:0]       mem_wr_i;
    logic [TAG_W-1:0] mem_req_tag_i;
    logic             mem_accept_o;
    logic             mem_ack_o;
    logic             mem_resp_ready_i;
    logic [31:0]      mem_data_rd_o;
    logic [TAG_W-1:0] mem_resp_tag_o;
    logic             mem_error_o;

    modport slave (
        input  mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_req_tag_i,
        input  mem_resp_ready_i,
        output mem_accept_o, mem_ack_o, mem_data_rd_o, mem_resp_tag_o, mem_error_o
    );

    modport master (
        output mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_req_tag_i,
        output mem_resp_ready_i,
        input  mem_accept_o, mem_ack_o, mem_data_rd_o, mem_resp_tag_o, mem_error_o
    );
endinterface

// File: rtl/tcm_dport_adapter.sv
// ----------------------------------------------------------------------------
// tcm_dport_adapter
// Adapts a 32-bit byte-addressed CPU data port onto one port of a 64-bit TCM
// RAM with a fixed 1-cycle read latency. Write strobes are steered onto the
// addressed 32-bit half, the read half is selected on return, and responses
// are buffered in a small in-order FIFO so the requester may back-pressure.
//
// Ports:
//   clk_i, rst_i       clock (posedge) / synchronous active-high reset
//   mem                tcm_dport_adapter_if.slave (CPU request/response)
//   ram_addr_o[13:0]   RAM word address = mem_addr_i[16:3]
//   ram_data_wr_o[63:0] write data replicated on both halves
//   ram_wr_o[7:0]      RAM byte enables
//   ram_data_rd_i[63:0] RAM read data, valid the cycle after the address
//
// Optional feature macro: TCM_DPORT_ERR_EN
//   Defined: accesses outside [BASE_ADDR, BASE_ADDR+128KB) are accepted but do
//   not write the RAM and respond with mem_error_o=1 and data 0.
//   Undefined: mem_error_o is 0 and the TCM aliases across all addresses.
// ----------------------------------------------------------------------------
module tcm_dport_adapter #(
    parameter int          RESP_DEPTH = 2,
    parameter int          TAG_W      = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tcm_dport_adapter_if.slave   mem,
    output logic [13:0]          ram_addr_o,
    output logic [63:0]          ram_data_wr_o,
    output logic [7:0]           ram_wr_o,
    input  logic [63:0]          ram_data_rd_i
);
    localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

    // Request side
    logic          req_wr;
    logic          req;
    logic          accept;
    logic          acc;
    logic          addr_err;
    logic [CW-1:0] occ;

    // Registered state of the access that is in the RAM this cycle
    logic             inflight_q;
    logic             half_q;
    logic             wr_q;
    logic             err_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      resp_data;

    // Response FIFO
    logic [31:0]      fifo_data [RESP_DEPTH];
    logic [TAG_W-1:0] fifo_tag  [RESP_DEPTH];
    logic             fifo_err  [RESP_DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    logic             ack;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    assign req_wr = |mem.mem_wr_i;
    assign req    = mem.mem_rd_i | req_wr;

`ifdef TCM_DPORT_ERR_EN
    logic [31:0] addr_off;
    logic        unused_addr;
    // Unsigned offset keeps the window check correct even near 2^32.
    assign addr_off    = mem.mem_addr_i - BASE_ADDR;
    assign addr_err    = |addr_off[31:17];
    assign unused_addr = ^{addr_off[16:0], mem.mem_addr_i[1:0]};
`else
    logic unused_addr;
    assign addr_err    = 1'b0;
    assign unused_addr = ^{mem.mem_addr_i[31:17], mem.mem_addr_i[1:0], BASE_ADDR};
`endif

    // Pops in the same cycle are deliberately not credited: keeps accept off
    // the response-ready path at the cost of needing RESP_DEPTH>=2 for
    // full throughput.
    assign occ    = count_q + CW'(inflight_q);
    assign accept = !rst_i && (occ < DEPTH_C);
    assign acc    = req && accept;

    assign ram_addr_o    = mem.mem_addr_i[16:3];
    assign ram_data_wr_o = {mem.mem_data_wr_i, mem.mem_data_wr_i};

    always_comb begin
        ram_wr_o = 8'h00;
        if (acc && req_wr && !addr_err) begin
            ram_wr_o = mem.mem_addr_i[2] ? {mem.mem_wr_i, 4'h0} : {4'h0, mem.mem_wr_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            half_q     <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= acc;
            if (acc) begin
                half_q <= mem.mem_addr_i[2];
                wr_q   <= req_wr;
                err_q  <= addr_err;
                tag_q  <= mem.mem_req_tag_i;
            end
        end
    end

    assign resp_data = (wr_q || err_q) ? 32'h0 :
                       (half_q ? ram_data_rd_i[63:32] : ram_data_rd_i[31:0]);

    // Empty FIFO: the RAM response is presented directly and only stored if
    // the requester stalls it. Otherwise the head is presented and every new
    // response queues behind it so ordering is preserved.
    always_comb begin
        ack      = 1'b0;
        out_data = 32'h0;
        out_tag  = '0;
        out_err  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (!rst_i) begin
            if (count_q == '0) begin
                ack  = inflight_q;
                push = inflight_q && !mem.mem_resp_ready_i;
                if (inflight_q) begin
                    out_data = resp_data;
                    out_tag  = tag_q;
                    out_err  = err_q;
                end
            end else begin
                ack      = 1'b1;
                pop      = mem.mem_resp_ready_i;
                push     = inflight_q;
                out_data = fifo_data[rptr_q];
                out_tag  = fifo_tag[rptr_q];
                out_err  = fifo_err[rptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wptr_q] <= resp_data;
            fifo_tag[wptr_q]  <= tag_q;
            fifo_err[wptr_q]  <= err_q;
        end
    end

    assign mem.mem_accept_o   = accept;
    assign mem.mem_ack_o      = ack;
    assign mem.mem_data_rd_o  = out_data;
    assign mem.mem_resp_tag_o = out_tag;
    assign mem.mem_error_o    = out_err;
endmodule

// File: tb/tb_tcm_dport_adapter.sv
// Bench for tcm_dport_adapter: directed requests, a behavioural read-first
// 64-bit RAM, and a scoreboard queue checked by a negedge monitor.
// RAM initial contents: word i = {32'hA000_0000|i, 32'h5000_0000|i}.
module tb_tcm_dport_adapter;
    localparam int W = 41;  // {err, tag[7:0], data[31:0]}
`ifdef TCM_DPORT_ERR_EN
    localparam logic [31:0] BASE = 32'h8000_0000;
`else
    localparam logic [31:0] BASE = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b1;
    logic [13:0] ram_addr;
    logic [63:0] ram_data_wr;
    logic [7:0]  ram_wr;
    logic [63:0] ram_rd = 64'h0;
    int          cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    int           cyc_q[$];

    tcm_dport_adapter_if #(.TAG_W(8)) bus();

    tcm_dport_adapter #(
        .RESP_DEPTH(2),
        .TAG_W(8),
        .BASE_ADDR(BASE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .mem(bus),
        .ram_addr_o(ram_addr),
        .ram_data_wr_o(ram_data_wr),
        .ram_wr_o(ram_wr),
        .ram_data_rd_i(ram_rd)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.mem_resp_ready_i = ready;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural RAM: read-first per edge, written bytes tracked by mask
    logic [63:0] ram_mem [16384];
    bit   [7:0]  ram_mask [16384];

    function automatic logic [63:0] ram_read(input logic [13:0] a);
        logic [63:0] iw;
        logic [63:0] r;
        iw = {32'hA000_0000 | {18'h0, a}, 32'h5000_0000 | {18'h0, a}};
        for (int b = 0; b < 8; b++) begin
            r[b*8 +: 8] = ram_mask[a][b] ? ram_mem[a][b*8 +: 8] : iw[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        ram_rd <= ram_read(ram_addr);
        for (int b = 0; b < 8; b++) begin
            if (ram_wr[b]) begin
                ram_mem[ram_addr][b*8 +: 8] <= ram_data_wr[b*8 +: 8];
                ram_mask[ram_addr][b]       <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Driver tasks
    task automatic idle();
        bus.mem_rd_i      = 1'b0;
        bus.mem_wr_i      = 4'h0;
        bus.mem_addr_i    = 32'h0;
        bus.mem_data_wr_i = 32'h0;
        bus.mem_req_tag_i = 8'h0;
    endtask

    // Drives a request (called just after a posedge), waits for accept,
    // checks the RAM-side request and pushes the expected response.
    task automatic send(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] tag,
                        input logic [7:0] exp_ram_wr, input logic [31:0] exp_data,
                        input logic exp_err, input bit strict, input bit lat);
        int waited;
        waited = 0;
        bus.mem_rd_i      = rd;
        bus.mem_wr_i      = wr;
        bus.mem_addr_i    = addr;
        bus.mem_data_wr_i = wdata;
        bus.mem_req_tag_i = tag;
        @(negedge clk);
        if (strict) check("accept_now", bus.mem_accept_o, 1'b1);
        while (!bus.mem_accept_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.mem_accept_o) begin
            check("accept_timeout", 1'b0, 1'b1);
        end else begin
            check("ram_addr", ram_addr, addr[16:3]);
            check("ram_wr", ram_wr, exp_ram_wr);
            if (wr != 4'h0) check("ram_data_wr", ram_data_wr, {wdata, wdata});
            exp_q.push_back({exp_err, tag, exp_data});
            cyc_q.push_back(lat ? cyc + 1 : -1);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard monitor
    logic [W-1:0] mon_e;
    int           mon_l;
    always @(negedge clk) begin
        if (!rst && bus.mem_ack_o && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_l = cyc_q.pop_front();
                check("resp_data", bus.mem_data_rd_o, mon_e[31:0]);
                check("resp_tag", bus.mem_resp_tag_o, mon_e[39:32]);
                check("resp_err", bus.mem_error_o, mon_e[40]);
                if (mon_l >= 0) check("resp_latency", cyc, mon_l);
            end
        end
    end

    initial begin
        idle();
        // Reset with a write request pending: nothing may leak out.
        rst = 1'b1;
        bus.mem_rd_i = 1'b1;
        bus.mem_wr_i = 4'hF;
        bus.mem_addr_i = 32'h8;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ack", bus.mem_ack_o, 1'b0);
            check("rst_accept", bus.mem_accept_o, 1'b0);
            check("rst_ram_wr", ram_wr, 8'h00);
            check("rst_data", bus.mem_data_rd_o, 32'h0);
            check("rst_tag", bus.mem_resp_tag_o, 8'h0);
            check("rst_err", bus.mem_error_o, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        // Full-word write, then partial write + read-after-write
        send(1'b0, 4'hF, BASE | 32'h8, 32'hDEAD_BEEF, 8'h10, 8'h0F, 32'h0, 1'b0, 1'b1, 1'b1);
        send(1'b0, 4'b0011, BASE | 32'hC, 32'h1234_ABCD, 8'h11, 8'h30, 32'h0, 1'b0, 1'b1, 1'b1);
        send(1'b1, 4'h0, BASE | 32'hC, 32'h0, 8'h12, 8'h00, 32'hA000_ABCD, 1'b0, 1'b1, 1'b1);
        send(1'b1, 4'h0, BASE | 32'h8, 32'h0, 8'h13, 8'h00, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
`ifndef TCM_DPORT_ERR_EN
        // Upper address bits ignored: aliases onto word 1
        send(1'b1, 4'h0, 32'h0002_0008, 32'h0, 8'h14, 8'h00, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
`endif
        // Single byte lane in the upper half; rd+wr together acts as a write
        send(1'b0, 4'b1000, BASE | 32'h14, 32'h7700_0000, 8'h15, 8'h80, 32'h0, 1'b0, 1'b1, 1'b1);
        send(1'b1, 4'h0, BASE | 32'h14, 32'h0, 8'h16, 8'h00, 32'h7700_0002, 1'b0, 1'b1, 1'b1);
        send(1'b1, 4'b0001, BASE | 32'h10, 32'h0000_00EE, 8'h17, 8'h01, 32'h0, 1'b0, 1'b1, 1'b1);
        send(1'b1, 4'h0, BASE | 32'h10, 32'h0, 8'h18, 8'h00, 32'h5000_00EE, 1'b0, 1'b1, 1'b1);
        drain();

        // Back-pressure: tags 1,2,3 with ready low for three cycles
        ready = 1'b0;
        send(1'b1, 4'h0, BASE | 32'h18, 32'h0, 8'h01, 8'h00, 32'h5000_0003, 1'b0, 1'b1, 1'b0);
        send(1'b1, 4'h0, BASE | 32'h1C, 32'h0, 8'h02, 8'h00, 32'hA000_0003, 1'b0, 1'b1, 1'b0);
        bus.mem_rd_i = 1'b1;
        bus.mem_addr_i = BASE | 32'h20;
        bus.mem_req_tag_i = 8'h03;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_accept_low", bus.mem_accept_o, 1'b0);
            check("bp_ram_wr", ram_wr, 8'h00);
            check("bp_ack", bus.mem_ack_o, 1'b1);
            check("bp_tag_hold", bus.mem_resp_tag_o, 8'h01);
            check("bp_data_hold", bus.mem_data_rd_o, 32'h5000_0003);
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        send(1'b1, 4'h0, BASE | 32'h20, 32'h0, 8'h03, 8'h00, 32'h5000_0004, 1'b0, 1'b0, 1'b0);
        drain();

        // Streaming: 16 reads, accept every cycle, latency 1
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 4'h0, BASE | (32'h100 + 32'(4 * i)), 32'h0, 8'h40 + 8'(i), 8'h00,
                 (i % 2 == 1) ? (32'hA000_0020 + 32'(i / 2)) : (32'h5000_0020 + 32'(i / 2)),
                 1'b0, 1'b1, 1'b1);
        end
        drain();

        // Reset with two responses buffered
        ready = 1'b0;
        send(1'b1, 4'h0, BASE | 32'h8, 32'h0, 8'h60, 8'h00, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        send(1'b1, 4'h0, BASE | 32'h10, 32'h0, 8'h61, 8'h00, 32'h5000_00EE, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_ack", bus.mem_ack_o, 1'b0);
        check("rst2_accept", bus.mem_accept_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        @(negedge clk);
        check("rst2_ack_after", bus.mem_ack_o, 1'b0);
        check("rst2_accept_after", bus.mem_accept_o, 1'b1);
        @(posedge clk);
        #1;
        ready = 1'b1;
        send(1'b1, 4'h0, BASE | 32'h8, 32'h0, 8'h55, 8'h00, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
        drain();

`ifdef TCM_DPORT_ERR_EN
        // Outside the window: no RAM write, error response
        send(1'b0, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 8'h70, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1);
        send(1'b1, 4'h0, 32'h0000_0010, 32'h0, 8'h71, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1);
        send(1'b1, 4'h0, BASE | 32'h10, 32'h0, 8'h72, 8'h00, 32'h5000_00EE, 1'b0, 1'b1, 1'b1);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
